// File: rtl/dll_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// dll_tx_scheduler_if
// Bus bundle for the data-link-layer transmit scheduler.
//   replay control : replay_req_i, replay_beats_i, ack_progress_i
//   retry buffer   : rd_en_o, rbuf_data_i, rbuf_data_en_i, rbuf_space_i
//   packetizer     : tlp_data_i, tlp_valid_i, tlp_last_i, tlp_ready_o,
//                    tlp_wr_en_o
//   DLLP generator : dllp_data_i, dllp_valid_i, dllp_ready_o
//   PIPE output    : data_o, data_en_o, replay_rollover_o
// slave  = scheduler side, master = environment side.
// ---------------------------------------------------------------------------
interface dll_tx_scheduler_if #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int RETRY_DEPTH_LG2 = 8
);
  logic                       replay_req_i;
  logic [RETRY_DEPTH_LG2-1:0] replay_beats_i;
  logic                       ack_progress_i;
  logic                       rd_en_o;
  logic [PIPE_DATA_WIDTH-1:0] rbuf_data_i;
  logic                       rbuf_data_en_i;
  logic [RETRY_DEPTH_LG2-1:0] rbuf_space_i;
  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
  logic                       tlp_valid_i;
  logic                       tlp_last_i;
  logic                       tlp_ready_o;
  logic                       tlp_wr_en_o;
  logic [63:0]                dllp_data_i;
  logic                       dllp_valid_i;
  logic                       dllp_ready_o;
  logic [PIPE_DATA_WIDTH-1:0] data_o;
  logic                       data_en_o;
  logic                       replay_rollover_o;

  modport slave (
    input  replay_req_i, replay_beats_i, ack_progress_i,
    input  rbuf_data_i, rbuf_data_en_i, rbuf_space_i,
    input  tlp_data_i, tlp_valid_i, tlp_last_i,
    input  dllp_data_i, dllp_valid_i,
    output rd_en_o, tlp_ready_o, tlp_wr_en_o, dllp_ready_o,
    output data_o, data_en_o, replay_rollover_o
  );

  modport master (
    output replay_req_i, replay_beats_i, ack_progress_i,
    output rbuf_data_i, rbuf_data_en_i, rbuf_space_i,
    output tlp_data_i, tlp_valid_i, tlp_last_i,
    output dllp_data_i, dllp_valid_i,
    input  rd_en_o, tlp_ready_o, tlp_wr_en_o, dllp_ready_o,
    input  data_o, data_en_o, replay_rollover_o
  );
endinterface

// File: rtl/dll_tx_scheduler.sv
// ---------------------------------------------------------------------------
// dll_tx_scheduler
// Shares the PIPE output between new TLP beats, retry-buffer replay beats and
// DLLPs. Sequences retry-buffer reads during replay, counts replays (with a
// rollover pulse) and only starts a new TLP when the retry buffer has room.
// Ports:
//   sclk  - clock
//   srst  - synchronous active-high reset; drops all in-flight work
//   bus   - dll_tx_scheduler_if.slave (see interface file for signal list)
// data_o, data_en_o and replay_rollover_o are registered; ready/strobe
// outputs are decoded from the registered state and same-cycle arbitration.
// ---------------------------------------------------------------------------
module dll_tx_scheduler #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int REPLAY_NUM_MAX  = 3,
  parameter int DLLP_STARVE_MAX = 16,
  parameter int TLP_SPACE_MIN   = 136
) (
  input logic               sclk,
  input logic               srst,
  dll_tx_scheduler_if.slave bus
);

  localparam int WAIT_W = $clog2(DLLP_STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0]          STARVE_C    = WAIT_W'(DLLP_STARVE_MAX);
  localparam logic [RETRY_DEPTH_LG2-1:0] SPACE_MIN_C = RETRY_DEPTH_LG2'(TLP_SPACE_MIN);
  localparam logic [RETRY_DEPTH_LG2-1:0] ONE_BEAT_C  = RETRY_DEPTH_LG2'(1);
  localparam logic [1:0]                 NUM_MAX_C   = 2'(REPLAY_NUM_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TLP    = 2'd1,
    ST_REPLAY = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t                     state_r;
  logic                       pend_replay_r;
  logic [RETRY_DEPTH_LG2-1:0] pend_beats_r;
  logic [RETRY_DEPTH_LG2-1:0] beats_left_r;
  logic [1:0]                 replay_num_r;
  logic [WAIT_W-1:0]          wait_cnt_r;
  logic [PIPE_DATA_WIDTH-1:0] data_r;
  logic                       data_en_r;
  logic                       rollover_r;

  logic                       req_ok_s;
  logic                       pend_eff_s;
  logic [RETRY_DEPTH_LG2-1:0] beats_eff_s;
  logic                       starved_s;
  logic                       grant_dllp_s;
  logic                       grant_replay_s;
  logic                       grant_tlp_s;
  logic                       tlp_ready_s;
  logic                       tlp_acc_s;

  // IDLE arbitration; a request arriving this cycle competes immediately
  always_comb begin
    req_ok_s       = bus.replay_req_i && (bus.replay_beats_i != '0);
    pend_eff_s     = pend_replay_r || req_ok_s;
    starved_s      = bus.dllp_valid_i && (wait_cnt_r >= STARVE_C);
    grant_dllp_s   = 1'b0;
    grant_replay_s = 1'b0;
    grant_tlp_s    = 1'b0;
    if (req_ok_s) begin
      beats_eff_s = bus.replay_beats_i;   // newest request wins
    end else begin
      beats_eff_s = pend_beats_r;
    end
    if (!srst && (state_r == ST_IDLE)) begin
      if (starved_s) begin
        grant_dllp_s = 1'b1;
      end else if (pend_eff_s) begin
        grant_replay_s = 1'b1;
      end else if (bus.dllp_valid_i) begin
        grant_dllp_s = 1'b1;
      end else if (bus.tlp_valid_i && (bus.rbuf_space_i >= SPACE_MIN_C)) begin
        grant_tlp_s = 1'b1;
      end else begin
        grant_tlp_s = 1'b0;
      end
    end else begin
      grant_tlp_s = 1'b0;
    end
    tlp_ready_s = !srst && (grant_tlp_s || (state_r == ST_TLP));
    tlp_acc_s   = bus.tlp_valid_i && tlp_ready_s;
  end

  assign bus.tlp_ready_o       = tlp_ready_s;
  assign bus.tlp_wr_en_o       = tlp_acc_s;
  assign bus.dllp_ready_o      = grant_dllp_s;
  assign bus.rd_en_o           = !srst && (state_r == ST_REPLAY);
  assign bus.data_o            = data_r;
  assign bus.data_en_o         = data_en_r;
  assign bus.replay_rollover_o = rollover_r;

  // FSM, replay bookkeeping, DLLP starvation counter and output register
  always_ff @(posedge sclk) begin
    if (srst) begin
      state_r       <= ST_IDLE;
      pend_replay_r <= 1'b0;
      pend_beats_r  <= '0;
      beats_left_r  <= '0;
      replay_num_r  <= 2'd0;
      wait_cnt_r    <= '0;
      data_r        <= '0;
      data_en_r     <= 1'b0;
      rollover_r    <= 1'b0;
    end else begin
      // pending replay: a grant consumes it, otherwise a new request latches
      if (grant_replay_s) begin
        pend_replay_r <= 1'b0;
      end else if (req_ok_s) begin
        pend_replay_r <= 1'b1;
        pend_beats_r  <= bus.replay_beats_i;
      end

      case (state_r)
        ST_IDLE: begin
          if (grant_replay_s) begin
            beats_left_r <= beats_eff_s;
            state_r      <= ST_REPLAY;
          end else if (grant_tlp_s && !bus.tlp_last_i) begin
            state_r <= ST_TLP;
          end
        end
        ST_TLP: begin
          if (bus.tlp_valid_i && bus.tlp_last_i) begin
            state_r <= ST_IDLE;
          end
        end
        ST_REPLAY: begin
          beats_left_r <= beats_left_r - ONE_BEAT_C;
          if (beats_left_r == ONE_BEAT_C) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // one slot so the last read beat cannot collide with the next source
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // replay count: an ACK in the grant cycle clears first, so result is 1
      rollover_r <= 1'b0;
      if (grant_replay_s) begin
        if (bus.ack_progress_i) begin
          replay_num_r <= 2'd1;
        end else if (replay_num_r == NUM_MAX_C) begin
          replay_num_r <= 2'd0;
          rollover_r   <= 1'b1;
        end else begin
          replay_num_r <= replay_num_r + 2'd1;
        end
      end else if (bus.ack_progress_i) begin
        replay_num_r <= 2'd0;
      end

      if (grant_dllp_s) begin
        wait_cnt_r <= '0;
      end else if (bus.dllp_valid_i && (wait_cnt_r < STARVE_C)) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end

      // sources are mutually exclusive by construction; order is defensive
      if (bus.rbuf_data_en_i) begin
        data_r    <= bus.rbuf_data_i;
        data_en_r <= 1'b1;
      end else if (tlp_acc_s) begin
        data_r    <= bus.tlp_data_i;
        data_en_r <= 1'b1;
      end else if (grant_dllp_s) begin
        data_r    <= {{(PIPE_DATA_WIDTH-64){1'b0}}, bus.dllp_data_i};
        data_en_r <= 1'b1;
      end else begin
        data_en_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dll_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dll_tx_scheduler
// Directed stimulus with a scoreboard: every beat expected on the PIPE
// output is queued with the cycle it must appear in; a monitor pops and
// compares whenever data_en_o is high. Control strobes are checked inline.
// ---------------------------------------------------------------------------
module tb_dll_tx_scheduler;
  localparam int W = 256;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic sclk = 1'b0;
  logic srst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // retry buffer model: read data appears one cycle after rd_en_o
  int           rd_idx = 0;
  logic         rb_en_r = 1'b0;
  logic [W-1:0] rb_data_r = '0;

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  dll_tx_scheduler_if #(.PIPE_DATA_WIDTH(W), .RETRY_DEPTH_LG2(8)) bus ();

  dll_tx_scheduler #(
    .PIPE_DATA_WIDTH(W), .RETRY_DEPTH_LG2(8), .REPLAY_NUM_MAX(3),
    .DLLP_STARVE_MAX(16), .TLP_SPACE_MIN(136)
  ) dut (
    .sclk(sclk),
    .srst(srst),
    .bus (bus.slave)
  );

  function automatic logic [W-1:0] rb_word(input int idx);
    logic [W-1:0] w;
    for (int l = 0; l < 8; l++) w[l*32 +: 32] = 32'hB000_0000 + 32'(idx * 16 + l);
    return w;
  endfunction

  function automatic logic [W-1:0] tlp_word(input int idx);
    logic [W-1:0] w;
    for (int l = 0; l < 8; l++) w[l*32 +: 32] = 32'hA000_0000 + 32'(idx * 16 + l);
    return w;
  endfunction

  function automatic logic [W-1:0] dllp_beat(input logic [63:0] d);
    logic [W-1:0] w;
    w = '0;
    w[63:0] = d;
    return w;
  endfunction

  always @(posedge sclk) begin
    if (bus.rd_en_o === 1'b1) begin
      rb_en_r   <= 1'b1;
      rb_data_r <= rb_word(rd_idx);
      rd_idx    <= rd_idx + 1;
    end else begin
      rb_en_r <= 1'b0;
    end
  end
  assign bus.rbuf_data_i    = rb_data_r;
  assign bus.rbuf_data_en_i = rb_en_r;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // monitor: every valid PIPE beat must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge sclk);
      if (bus.data_en_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none (cycle %0d)", bus.data_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", bus.data_o, mon_e.data);
          check("beat_cycle", W'(cyc), W'(mon_e.cyc));
        end
      end
    end
  end

  task automatic tlp_beat(input int idx, input logic last, input logic exp_rdy);
    bus.tlp_valid_i = 1'b1;
    bus.tlp_data_i  = tlp_word(idx);
    bus.tlp_last_i  = last;
    #1;
    check("tlp_ready", W'(bus.tlp_ready_o), W'(exp_rdy));
    check("tlp_wr_en", W'(bus.tlp_wr_en_o), W'(exp_rdy));
    if (exp_rdy) push(tlp_word(idx), cyc + 1);
    step();
  endtask

  // single replay issued from IDLE; grant at g, reads g+1..g+n, drain g+n+1
  task automatic do_replay(input int n, input logic ack, input logic exp_roll);
    int g;
    int base;
    g    = cyc;
    base = rd_idx;
    bus.replay_req_i   = 1'b1;
    bus.replay_beats_i = 8'(n);
    bus.ack_progress_i = ack;
    for (int i = 0; i < n; i++) push(rb_word(base + i), g + 3 + i);
    step();
    bus.replay_req_i   = 1'b0;
    bus.ack_progress_i = 1'b0;
    #1;
    check("rollover_after_grant", W'(bus.replay_rollover_o), W'(exp_roll));
    check("replay_rd_en", W'(bus.rd_en_o), W'(1));
    for (int i = 1; i < n; i++) begin
      step();
      check("replay_rd_en", W'(bus.rd_en_o), W'(1));
    end
    step();
    check("drain_rd_en", W'(bus.rd_en_o), W'(0));
    check("rollover_single", W'(bus.replay_rollover_o), W'(0));
    step();
  endtask

  initial begin
    int g;
    int base;
    srst = 1'b1;
    bus.replay_req_i   = 1'b0;
    bus.replay_beats_i = 8'd0;
    bus.ack_progress_i = 1'b0;
    bus.rbuf_space_i   = 8'd200;
    bus.tlp_data_i     = '0;
    bus.tlp_valid_i    = 1'b0;
    bus.tlp_last_i     = 1'b0;
    bus.dllp_data_i    = 64'd0;
    bus.dllp_valid_i   = 1'b0;
    repeat (3) step();
    check("rst_data_en", W'(bus.data_en_o), W'(0));
    check("rst_data", bus.data_o, '0);
    check("rst_rd_en", W'(bus.rd_en_o), W'(0));
    check("rst_rollover", W'(bus.replay_rollover_o), W'(0));
    check("rst_dllp_ready", W'(bus.dllp_ready_o), W'(0));
    check("rst_tlp_ready", W'(bus.tlp_ready_o), W'(0));
    srst = 1'b0;
    step();

    // 3-beat TLP with ample space
    tlp_beat(0, 1'b0, 1'b1);
    tlp_beat(1, 1'b0, 1'b1);
    tlp_beat(2, 1'b1, 1'b1);

    // space gate: back in IDLE, 100 DW refused, 136 DW starts immediately
    bus.rbuf_space_i = 8'd100;
    tlp_beat(3, 1'b1, 1'b0);
    tlp_beat(3, 1'b1, 1'b0);
    bus.rbuf_space_i = 8'd136;
    tlp_beat(3, 1'b1, 1'b1);
    bus.tlp_valid_i  = 1'b0;
    bus.rbuf_space_i = 8'd200;

    // plain DLLP outranks a new TLP
    bus.dllp_valid_i = 1'b1;
    bus.dllp_data_i  = 64'h1234_5678_9ABC_DEF0;
    bus.tlp_valid_i  = 1'b1;
    bus.tlp_data_i   = tlp_word(4);
    bus.tlp_last_i   = 1'b1;
    #1;
    check("dllp_over_tlp", W'(bus.dllp_ready_o), W'(1));
    check("tlp_held_by_dllp", W'(bus.tlp_ready_o), W'(0));
    push(dllp_beat(64'h1234_5678_9ABC_DEF0), cyc + 1);
    step();
    bus.dllp_valid_i = 1'b0;
    tlp_beat(4, 1'b1, 1'b1);
    bus.tlp_valid_i = 1'b0;

    // replay request during beat 2 of a 4-beat TLP (with a bubble)
    tlp_beat(10, 1'b0, 1'b1);
    bus.replay_req_i   = 1'b1;
    bus.replay_beats_i = 8'd4;
    tlp_beat(11, 1'b0, 1'b1);
    bus.replay_req_i = 1'b0;
    bus.tlp_valid_i  = 1'b0;
    #1;
    check("tlp_bubble_ready", W'(bus.tlp_ready_o), W'(1));
    step();
    tlp_beat(12, 1'b0, 1'b1);
    tlp_beat(13, 1'b1, 1'b1);
    bus.tlp_valid_i = 1'b0;
    g    = cyc;
    base = rd_idx;
    #1;
    check("replay_grant_no_rd", W'(bus.rd_en_o), W'(0));
    for (int i = 0; i < 4; i++) push(rb_word(base + i), g + 3 + i);
    for (int i = 0; i < 4; i++) begin
      step();
      check("midtlp_rd_en", W'(bus.rd_en_o), W'(1));
    end
    step();
    check("midtlp_drain", W'(bus.rd_en_o), W'(0));
    step();

    // zero-beat request is ignored
    bus.replay_req_i   = 1'b1;
    bus.replay_beats_i = 8'd0;
    step();
    bus.replay_req_i = 1'b0;
    check("zero_beats_ignored", W'(bus.rd_en_o), W'(0));
    step();
    check("zero_beats_ignored2", W'(bus.rd_en_o), W'(0));

    // rollover: clear count, then 4 replays without ACK
    bus.ack_progress_i = 1'b1;
    step();
    bus.ack_progress_i = 1'b0;
    do_replay(1, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b1);
    // ACK between replays 2 and 3 suppresses the pulse
    do_replay(2, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b0);
    bus.ack_progress_i = 1'b1;
    step();
    bus.ack_progress_i = 1'b0;
    do_replay(1, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b0);
    // ACK coinciding with a grant leaves count 1; pulse on the 4th grant
    do_replay(1, 1'b1, 1'b0);
    do_replay(1, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b0);
    do_replay(1, 1'b0, 1'b1);

    // starvation: replay wins first, then a starved DLLP beats a new replay
    g    = cyc;
    base = rd_idx;
    bus.dllp_valid_i   = 1'b1;
    bus.dllp_data_i    = 64'hDEAD_BEEF_0BAD_F00D;
    bus.replay_req_i   = 1'b1;
    bus.replay_beats_i = 8'd20;
    #1;
    check("replay_before_dllp", W'(bus.dllp_ready_o), W'(0));
    for (int i = 0; i < 20; i++) push(rb_word(base + i), g + 3 + i);
    step();
    bus.replay_req_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) begin
        bus.replay_req_i   = 1'b1;
        bus.replay_beats_i = 8'd2;
      end
      check("long_replay_rd_en", W'(bus.rd_en_o), W'(1));
      step();
      bus.replay_req_i = 1'b0;
    end
    check("long_drain_rd_en", W'(bus.rd_en_o), W'(0));
    check("long_drain_dllp", W'(bus.dllp_ready_o), W'(0));
    step();
    check("starved_dllp_grant", W'(bus.dllp_ready_o), W'(1));
    check("starved_dllp_no_rd", W'(bus.rd_en_o), W'(0));
    push(dllp_beat(64'hDEAD_BEEF_0BAD_F00D), cyc + 1);
    step();
    bus.dllp_valid_i = 1'b0;
    g    = cyc;
    base = rd_idx;
    #1;
    check("pending_grant_no_rd", W'(bus.rd_en_o), W'(0));
    for (int i = 0; i < 2; i++) push(rb_word(base + i), g + 3 + i);
    step();
    check("pending_rd_en", W'(bus.rd_en_o), W'(1));
    step();
    check("pending_rd_en", W'(bus.rd_en_o), W'(1));
    step();
    check("pending_drain", W'(bus.rd_en_o), W'(0));
    step();

    // reset at beat 2 of an 8-beat replay, with another replay pending
    bus.replay_req_i   = 1'b1;
    bus.replay_beats_i = 8'd8;
    step();
    bus.replay_req_i   = 1'b1;
    bus.replay_beats_i = 8'd3;
    check("rst_replay_beat1", W'(bus.rd_en_o), W'(1));
    step();
    bus.replay_req_i = 1'b0;
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("postrst_rd_en", W'(bus.rd_en_o), W'(0));
    check("postrst_data_en", W'(bus.data_en_o), W'(0));
    check("postrst_data", bus.data_o, '0);
    check("postrst_rollover", W'(bus.replay_rollover_o), W'(0));
    check("postrst_tlp_ready", W'(bus.tlp_ready_o), W'(0));
    check("postrst_tlp_wr_en", W'(bus.tlp_wr_en_o), W'(0));
    check("postrst_dllp_ready", W'(bus.dllp_ready_o), W'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check("postrst_no_read", W'(bus.rd_en_o), W'(0));
    end

    repeat (4) step();
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dll_tx_scheduler.md
Name: dll_tx_scheduler

Overview:
Data-link-layer transmit scheduler. It shares the single 256-bit PIPE output between three sources: new TLP beats from the packetizer, replay beats read from the retry buffer, and DLLPs from the ACK/NAK/FC generator. It sequences retry-buffer reads during replay, tracks the replay count, and gates new TLPs on retry-buffer space.

Parameters:
PIPE_DATA_WIDTH, 256, PIPE beat width; 8 DW lanes of 32 b.
RETRY_DEPTH_LG2, 8, log2 of retry buffer depth in beats.
REPLAY_NUM_MAX, 3, replays allowed before the rollover pulse.
DLLP_STARVE_MAX, 16, DLLP wait cycles after which the DLLP outranks a pending replay.
TLP_SPACE_MIN, 136, minimum retry-buffer free space (DW) required to start a new TLP.

Ports:
sclk  in  1  clock
srst  in  1  synchronous active-high reset
replay_req_i  in  1  pulse: replay requested (NAK or timeout)
replay_beats_i  in  RETRY_DEPTH_LG2  beats to replay; sampled with replay_req_i
ack_progress_i  in  1  pulse: ACK advanced AS; clears replay count
rd_en_o  out  1  retry buffer read strobe
rbuf_data_i  in  8x32  retry buffer read data; valid one cycle after rd_en_o
rbuf_data_en_i  in  1  rbuf_data_i valid
rbuf_space_i  in  RETRY_DEPTH_LG2  retry buffer free space, DW
tlp_data_i  in  8x32  packetizer beat
tlp_valid_i  in  1  packetizer beat valid
tlp_last_i  in  1  last beat of TLP
tlp_ready_o  out  1  beat accepted when tlp_valid_i & tlp_ready_o
tlp_wr_en_o  out  1  accepted beat; drives retry-buffer write enable
dllp_data_i  in  64  SDP token plus DLLP, 2 DW
dllp_valid_i  in  1  DLLP pending
dllp_ready_o  out  1  DLLP accepted this cycle
data_o  out  8x32  PIPE beat to PHY; registered
data_en_o  out  1  data_o valid; registered
replay_rollover_o  out  1  one-cycle pulse: replay count exceeded REPLAY_NUM_MAX

Behaviour:
- Reset: every output is 0. State goes to IDLE. Pending replay, replay_num and the starvation counter clear. Reset mid-packet or mid-replay drops all in-flight work.
- FSM states: IDLE, TLP, REPLAY, DRAIN.
- Pending replay: replay_req_i sets pend_replay and stores replay_beats_i. A newer request overwrites the stored count. A request with replay_beats_i == 0 is ignored.
- IDLE arbitration, one decision per cycle. Priority order:
  1. Starved DLLP: dllp_wait_cnt >= DLLP_STARVE_MAX.
  2. pend_replay.
  3. dllp_valid_i.
  4. New TLP, only if tlp_valid_i and rbuf_space_i >= TLP_SPACE_MIN.
- IDLE, DLLP grant: dllp_ready_o = 1 for that cycle; state stays IDLE.
- IDLE, replay grant: load beats_left, clear pend_replay, go to REPLAY.
- IDLE, TLP grant: accept the first beat the same cycle. If it is not tlp_last_i, go to TLP.
- A request arriving while IDLE with nothing pending is seen by arbitration in the same cycle.
- TLP state: tlp_ready_o = 1. The TLP cannot be interrupted. A cycle without tlp_valid_i gives data_en_o = 0 for that slot. The accepted tlp_last_i beat returns the FSM to IDLE. Space is checked only at TLP start.
- REPLAY state: rd_en_o = 1 and beats_left decrements each cycle. The cycle with beats_left == 1 is the last read; go to DRAIN. DRAIN lasts one cycle so the last read data cannot collide with the next source, then return to IDLE.
- A replay_req_i during TLP, REPLAY or DRAIN is latched as pending and served from IDLE.
- Output register: data_o/data_en_o load the cycle after a beat is accepted.
  - TLP: accepted beat.
  - Replay: rbuf_data_i when rbuf_data_en_i; rd_en_o at t gives data_en_o at t+2.
  - DLLP: lanes 0-1 = dllp_data_i[31:0], [63:32]; lanes 2-7 = 0.
  - Otherwise data_en_o = 0 and data_o holds its value.
- tlp_wr_en_o = tlp_valid_i & tlp_ready_o, combinational.
- replay_num (2 b) increments on each replay grant. If it already equals REPLAY_NUM_MAX: set it to 0, pulse replay_rollover_o the next cycle, and still perform the replay.
- ack_progress_i clears replay_num. If it coincides with a replay grant, the clear applies first, then the increment, so the result is 1.
- dllp_wait_cnt: increments while dllp_valid_i & ~dllp_ready_o, saturates at DLLP_STARVE_MAX, and clears on accept.

Test Plan:
- New TLP: 3-beat TLP, rbuf_space_i = 200 -> tlp_ready_o high for 3 cycles, tlp_wr_en_o x3, data_en_o on cycles 1-3 after the first accept, returns to IDLE.
- Space gate: rbuf_space_i = 100, tlp_valid_i held -> tlp_ready_o stays 0. Raise rbuf_space_i to 136 -> TLP starts that cycle.
- Replay mid-TLP: replay_req_i with beats = 4 during beat 2 of a 4-beat TLP -> TLP completes, then rd_en_o for 4 cycles, 1 DRAIN cycle, and data_en_o carries the 4 rbuf beats at rd_en_o+2.
- Rollover: 4 replays with no ACK -> replay_rollover_o pulses once, after the 4th grant, with replay_num = 0. An ACK between replays 2 and 3 suppresses the pulse.
- DLLP starvation: DLLP and replay both pending, wait_cnt < 16 -> replay first. Hold the DLLP 16 cycles through a long replay -> the DLLP is granted ahead of a new pending replay, in lanes 0-1 only.
- Reset mid-replay: srst high at beat 2 of 8 -> next cycle all outputs 0, IDLE, pending replay cleared, no further rd_en_o.
